mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle main control unit for the RISC-V core: a Moore-style FSM that sequences each instruction over several cycles (fetch, decode, execute, memory, writeback) instead of decoding it in one combinational step. It sits beside the shared datapath (single ALU, unified memory port, instruction register) and drives every mux select and write enable. It also handshakes with a variable-latency memory through `mem_ready`, and guards that memory handshake with a watchdog.

## Interface
- `data_width`, 32: datapath width; carried for consistency, no effect on control logic.
- `MEM_WAIT_MAX`, 15: maximum cycles to wait for `mem_ready` in a memory state; 0 disables the watchdog.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `op` input 7: opcode field of the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current request this cycle.
- `memread` output 1: memory read request.
- `memwrite` output 1: memory write request.
- `adrsrc` output 1: memory address select, 0 = PC, 1 = ALU result register.
- `irwrite` output 1: load the instruction register.
- `pcwrite` output 1: load the PC; equals `pcupdate | (branch & zero)`.
- `regwrite` output 1: register file write enable.
- `alusrca` output 2: ALU A select, 00 = PC, 01 = old PC, 10 = rs1.
- `alusrcb` output 2: ALU B select, 00 = rs2, 01 = immediate, 10 = constant 4.
- `aluop` output 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `resultsrc` output 2: result select, 00 = ALU out register, 01 = data register, 10 = ALU result.
- `branch` output 1: branch evaluation cycle.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `mem_err` output 1: one-cycle pulse on watchdog expiry.
- `instr_done` output 1: one-cycle pulse when an instruction retires.

## Operation
- Opcodes:
  - R-type 0110011
  - lw 0000011
  - sw 0100011
  - beq 1100011
  - I-ALU 0010011 (macro-gated)
  - jal 1101111 (macro-gated)
- Any output not listed for a state is 0.
- FETCH: `memread`=1, `adrsrc`=0, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10.
  - While `mem_ready`=0: hold in FETCH.
  - When `mem_ready`=1 in the same cycle: `irwrite`=1, `pcupdate`=1, next state DECODE.
- DECODE: `alusrca`=01, `alusrcb`=01 (branch target precompute).
  - lw or sw → MEMADR; R-type → EXECUTER; beq → BEQ; I-ALU → EXECUTEI; jal → JAL.
  - Any other opcode: `illegal`=1, next state FETCH, nothing retires.
- MEMADR: `alusrca`=10, `alusrcb`=01. Next: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: `memread`=1, `adrsrc`=1. Holds until `mem_ready`=1, then → MEMWB.
- MEMWB: `resultsrc`=01, `regwrite`=1, `instr_done`=1. Next FETCH.
- MEMWRITE: `memwrite`=1, `adrsrc`=1. Holds until `mem_ready`=1; on that cycle `instr_done`=1, next FETCH.
- EXECUTER: `alusrca`=10, `alusrcb`=00, `aluop`=10. Next ALUWB.
- EXECUTEI: `alusrca`=10, `alusrcb`=01, `aluop`=10. Next ALUWB.
- ALUWB: `resultsrc`=00, `regwrite`=1, `instr_done`=1. Next FETCH.
- BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `branch`=1, `instr_done`=1. Next FETCH.
- JAL: `alusrca`=01, `alusrcb`=10, `pcupdate`=1. Next ALUWB.
- Watchdog (active only in FETCH, MEMREAD, MEMWRITE):
  - The counter increments each cycle that `mem_ready`=0.
  - The counter clears on any state change.
  - If `mem_ready`=0 and the count equals `MEM_WAIT_MAX`-1: `mem_err`=1, next state FETCH, and no `irwrite`, `pcupdate` or `regwrite` is issued.
  - `mem_ready`=1 on that same cycle wins; no error is raised.
- The counter is $clog2(MEM_WAIT_MAX+1) bits wide and saturates; it never wraps.

## Timing
- Reset: while `rst`=1, every output is forced to 0. On the first edge the state becomes FETCH and the counter clears. `memread` rises the cycle after `rst` falls.
- A `rst` assertion mid-instruction aborts the instruction; no partial write enables are issued.
- With zero-wait memory, cycles per instruction are:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq 3
  - jal 4
- Each memory wait cycle adds 1.
- `pcwrite`, `irwrite`, `instr_done` (MEMWRITE only) and `mem_err` are Mealy outputs, combinational on `mem_ready`/`zero`. All other outputs depend on state only.

## Configuration
- `MC_CONTROL_IMM_EN` defined: EXECUTEI and JAL exist, and opcodes 0010011 and 1101111 decode as described above.
- Not defined: neither state is instantiated, and both opcodes raise `illegal`.

## Structure
- Package `mc_pkg` holds:
  - the state enum
  - opcode constants
  - `aluop`, `alusrca`, `alusrcb` and `resultsrc` encodings
- Sub-module `mc_watchdog`: a saturating wait counter with a clear input and an expiry output, parameterised by `MEM_WAIT_MAX`.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `memread`=1 in the first FETCH cycle.
- R-type, `mem_ready` always 1 → FETCH, DECODE, EXECUTER, ALUWB; `regwrite` and `instr_done` both 1 in cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEMREAD → holds in MEMREAD for 4 cycles, then MEMWB with `regwrite`=1; total 8 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `pcwrite`=1 in BEQ only for `zero`=1.
- `MEM_WAIT_MAX`=4 and `mem_ready` stuck at 0 in FETCH → `mem_err` pulses in wait cycle 4; no `irwrite`; state re-enters FETCH.
- op=0010011 without the macro → `illegal`=1 in DECODE, then FETCH. With `MC_CONTROL_IMM_EN` defined → EXECUTEI then ALUWB.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle main control unit: state enum, opcodes, mux encodings.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
// MC_CONTROL_IMM_EN adds the EXECUTEI and JAL states.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8
`ifdef MC_CONTROL_IMM_EN
    ,
    S_EXECUTEI = 4'd9,
    S_JAL      = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // State-only (Moore) control word.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       adrsrc;
    logic       regwrite;
    logic       branch;
    logic       pcupdate;
    logic       done;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
  } ctrl_t;

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread   = 1'b1;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALU;
      end
      S_DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.memread = 1'b1;
        c.adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = 1'b1;
        c.done      = 1'b1;
      end
      S_MEMWRITE: begin
        c.memwrite = 1'b1;
        c.adrsrc   = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.regwrite  = 1'b1;
        c.done      = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.done    = 1'b1;
      end
`ifdef MC_CONTROL_IMM_EN
      S_EXECUTEI: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_FUNCT;
      end
      S_JAL: begin
        c.alusrca  = SRCA_OLDPC;
        c.alusrcb  = SRCB_FOUR;
        c.pcupdate = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_watchdog.sv
// Saturating memory-wait counter; flags expiry on the last allowed wait cycle.
// Latency: expired is combinational on ready and the registered count.
// Backpressure: none; clear has priority over counting, MEM_WAIT_MAX = 0 never expires.
module mc_watchdog
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);
  localparam logic [CW-1:0] CNT_EXP = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  // Count unanswered wait cycles, stopping at MEM_WAIT_MAX rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (active && !ready && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (MEM_WAIT_MAX != 0) && active && !ready && (cnt == CNT_EXP);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RISC-V main control FSM driving datapath selects and write enables.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles with zero-wait memory; +1 per mem wait cycle.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready; watchdog aborts to FETCH.
// MC_CONTROL_IMM_EN enables I-ALU (EXECUTEI) and jal (JAL) support.
module mc_control
  import mc_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic       branch,
  output logic       illegal,
  output logic       mem_err,
  output logic       instr_done
);

  // The datapath width does not affect sequencing; only reject nonsense values.
  if (data_width < 1) begin : g_bad_width
    $error("mc_control: data_width must be positive");
  end

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   op_bad;
  logic   wd_active;
  logic   wd_clear;
  logic   wd_exp;
  logic   run;
  logic   pcupdate;

  assign run       = !rst;
  assign wd_active = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // Restart the wait count on every state change, after an expiry, and outside wait states.
  assign wd_clear  = (nxt != state) || wd_exp || !wd_active;

  mc_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (wd_active),
    .ready  (mem_ready),
    .clear  (wd_clear),
    .expired(wd_exp)
  );

  // Next-state selection; also flags an unsupported opcode seen in DECODE.
  always_comb begin
    nxt    = state;
    op_bad = 1'b0;
    case (state)
      S_FETCH: begin
        // On expiry the state simply stays FETCH; the watchdog clear restarts the wait.
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTER;
          OP_BEQ:       nxt = S_BEQ;
`ifdef MC_CONTROL_IMM_EN
          OP_IALU:      nxt = S_EXECUTEI;
          OP_JAL:       nxt = S_JAL;
`endif
          default: begin
            nxt    = S_FETCH;
            op_bad = 1'b1;
          end
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)   nxt = S_MEMWB;
        else if (wd_exp) nxt = S_FETCH;
      end
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || wd_exp) nxt = S_FETCH;
      end
      S_EXECUTER: nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
`ifdef MC_CONTROL_IMM_EN
      S_EXECUTEI: nxt = S_ALUWB;
      S_JAL:      nxt = S_ALUWB;
`endif
      default:    nxt = S_FETCH;
    endcase
  end

  // State register with the Moore control word registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt);
    end
  end

  // Reset gates every output so an aborted instruction issues no partial writes.
  assign pcupdate   = ctrl_q.pcupdate || ((state == S_FETCH) && mem_ready);
  assign memread    = run && ctrl_q.memread;
  assign memwrite   = run && ctrl_q.memwrite;
  assign adrsrc     = run && ctrl_q.adrsrc;
  assign regwrite   = run && ctrl_q.regwrite;
  assign branch     = run && ctrl_q.branch;
  assign alusrca    = run ? ctrl_q.alusrca   : 2'b00;
  assign alusrcb    = run ? ctrl_q.alusrcb   : 2'b00;
  assign aluop      = run ? ctrl_q.aluop     : 2'b00;
  assign resultsrc  = run ? ctrl_q.resultsrc : 2'b00;
  assign irwrite    = run && (state == S_FETCH) && mem_ready;
  assign pcwrite    = run && (pcupdate || (ctrl_q.branch && zero));
  assign illegal    = run && op_bad;
  assign mem_err    = run && wd_exp;
  assign instr_done = run && (ctrl_q.done || ((state == S_MEMWRITE) && mem_ready));

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle output vectors against hand-computed values.
// Latency: n/a.
// Backpressure: mem_ready is driven per cycle to exercise waits and the watchdog.
module tb_mc_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // {memread,memwrite,adrsrc,irwrite,pcwrite,regwrite, alusrca,alusrcb,aluop,resultsrc,
  //  branch,illegal,mem_err,instr_done}
  localparam logic [17:0] V_RST     = 18'b000000_00000000_0000;
  localparam logic [17:0] V_FETCH_R = 18'b100110_00100010_0000;
  localparam logic [17:0] V_FETCH_W = 18'b100000_00100010_0000;
  localparam logic [17:0] V_FETCH_E = 18'b100000_00100010_0010;
  localparam logic [17:0] V_DEC     = 18'b000000_01010000_0000;
  localparam logic [17:0] V_DEC_ILL = 18'b000000_01010000_0100;
  localparam logic [17:0] V_EXE_R   = 18'b000000_10001000_0000;
  localparam logic [17:0] V_ALUWB   = 18'b000001_00000000_0001;
  localparam logic [17:0] V_MEMADR  = 18'b000000_10010000_0000;
  localparam logic [17:0] V_MEMRD   = 18'b101000_00000000_0000;
  localparam logic [17:0] V_MEMWB   = 18'b000001_00000001_0001;
  localparam logic [17:0] V_MEMWR_W = 18'b011000_00000000_0000;
  localparam logic [17:0] V_MEMWR_R = 18'b011000_00000000_0001;
  localparam logic [17:0] V_BEQ_T   = 18'b000010_10000100_1001;
  localparam logic [17:0] V_BEQ_N   = 18'b000000_10000100_1001;
  localparam logic [17:0] V_EXE_I   = 18'b000000_10011000_0000;
  localparam logic [17:0] V_JAL     = 18'b000010_01100000_0000;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memread, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc;
  logic       branch, illegal, mem_err, instr_done;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  mc_control #(
    .data_width  (32),
    .MEM_WAIT_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memread   (memread),
    .memwrite  (memwrite),
    .adrsrc    (adrsrc),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .resultsrc (resultsrc),
    .branch    (branch),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .instr_done(instr_done)
  );

  assign obs = {memread, memwrite, adrsrc, irwrite, pcwrite, regwrite,
                alusrca, alusrcb, aluop, resultsrc,
                branch, illegal, mem_err, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = OP_R; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== V_RST) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b, expected %b", i, obs, V_RST);
      end
      tick();
    end
    rst = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== V_FETCH_W) begin
      errors++;
      $display("FAIL reset_release: got %b, expected %b", obs, V_FETCH_W);
    end
    tick();
  endtask

  task automatic test_rtype();
    logic [17:0] ev [4];
    ev = '{V_FETCH_R, V_DEC, V_EXE_R, V_ALUWB};
    op = OP_R; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL rtype cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [17:0] ev [8];
    logic        rv [8];
    ev = '{V_FETCH_R, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = OP_LW; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rv[i];
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [17:0] ev [6];
    logic        rv [6];
    ev = '{V_FETCH_W, V_FETCH_R, V_DEC, V_MEMADR, V_MEMWR_W, V_MEMWR_R};
    rv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    op = OP_SW; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rv[i];
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [17:0] ev [6];
    logic        zv [6];
    ev = '{V_FETCH_R, V_DEC, V_BEQ_T, V_FETCH_R, V_DEC, V_BEQ_N};
    zv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op = OP_BEQ; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      zero = zv[i];
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL beq cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  // MEM_WAIT_MAX = 4: error on the 4th unanswered FETCH cycle, then a fresh count
  // where mem_ready arrives exactly on the would-be expiry cycle and wins.
  task automatic test_watchdog();
    logic [17:0] ev [11];
    logic        rv [11];
    ev = '{V_FETCH_W, V_FETCH_W, V_FETCH_W, V_FETCH_E,
           V_FETCH_W, V_FETCH_W, V_FETCH_W, V_FETCH_R,
           V_DEC, V_EXE_R, V_ALUWB};
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    op = OP_R; zero = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mem_ready = rv[i];
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL watchdog cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_ialu();
    logic [17:0] ev [4];
`ifdef MC_CONTROL_IMM_EN
    ev = '{V_FETCH_R, V_DEC, V_EXE_I, V_ALUWB};
`else
    ev = '{V_FETCH_R, V_DEC_ILL, V_FETCH_R, V_DEC_ILL};
`endif
    op = OP_I; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL ialu cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_jal();
    logic [17:0] ev [4];
`ifdef MC_CONTROL_IMM_EN
    ev = '{V_FETCH_R, V_DEC, V_JAL, V_ALUWB};
`else
    ev = '{V_FETCH_R, V_DEC_ILL, V_FETCH_R, V_DEC_ILL};
`endif
    op = OP_J; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL jal cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal_op();
    logic [17:0] ev [3];
    ev = '{V_FETCH_R, V_DEC_ILL, V_FETCH_R};
    op = OP_BAD; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) op = OP_R;
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
    // Finish the R-type started above so the next test begins in FETCH.
    tick(); tick(); tick();
  endtask

  // Reset in the middle of a lw: nothing may be enabled while rst is high,
  // and the FSM restarts in FETCH.
  task automatic test_reset_abort();
    logic [17:0] ev [7];
    logic        rv [7];
    logic        sv [7];
    ev = '{V_FETCH_R, V_DEC, V_MEMADR, V_RST, V_RST, V_FETCH_W, V_FETCH_R};
    rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    op = OP_LW; zero = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rv[i];
      rst       = sv[i];
      @(negedge clk);
      checks++;
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL reset_abort cyc%0d: got %b, expected %b", i, obs, ev[i]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; op = OP_R; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_watchdog();
    test_ialu();
    test_jal();
    test_illegal_op();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
